// File: rtl/mod_counter_pkg.sv
// Shared constants and operation select for the up/down counter.
// Holds direction/mode encodings and the clr > load > count > hold priority.
package mod_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        OP_CLR   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2,
        OP_HOLD  = 2'd3
    } op_e;

    // Priority encode the per-edge operation.
    function automatic op_e op_sel(
        input logic clr,
        input logic load,
        input logic en
    );
        op_e op;
        if (clr)       op = OP_CLR;
        else if (load) op = OP_LOAD;
        else if (en)   op = OP_COUNT;
        else           op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and terminal-event logic.
// In: q, limit, up_dn, sat_mode, op, load_val. Out: next_q, term_evt.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  op_e              op,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_q,
    output logic             term_evt
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    always_comb begin
        next_q   = q;
        term_evt = 1'b0;
        unique case (op)
            OP_CLR: begin
                next_q = ZERO;
            end
            OP_LOAD: begin
                next_q = (load_val > limit) ? limit : load_val;
            end
            OP_COUNT: begin
                if (up_dn == DIR_UP) begin
                    // q >= limit also covers a limit lowered below q;
                    // q < limit guarantees q+1 cannot roll over.
                    if (q >= limit) begin
                        term_evt = 1'b1;
                        next_q   = (sat_mode == MODE_SAT) ? limit : ZERO;
                    end else begin
                        next_q = q + ONE;
                    end
                end else begin
                    if (q == ZERO) begin
                        term_evt = 1'b1;
                        next_q   = (sat_mode == MODE_SAT) ? ZERO : limit;
                    end else begin
                        next_q = q - ONE;
                    end
                end
            end
            OP_HOLD: begin
                next_q = q;
            end
            default: begin
                next_q = q;
            end
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with runtime limit, wrap/saturate mode,
// terminal-count pulse tc and sticky overflow ovf. Async active-low reset.
// Ports: clk, reset, en, up_dn, clr, load, load_val, limit, sat_mode,
//        ovf_clr -> q, tc, ovf.
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             term_evt;
    op_e              op;

    assign op = op_sel(clr, load, en);

    mod_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q        (q_q),
        .limit    (limit),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .op       (op),
        .load_val (load_val),
        .next_q   (q_d),
        .term_evt (term_evt)
    );

    // tc mirrors the event that produced the new q; a fresh event
    // overrides a same-edge ovf_clr.
    assign tc_d  = term_evt;
    assign ovf_d = term_evt | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= RESET_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
